// File: rtl/serv_sram8_pkg.sv
// Shared types and constants for the SERV dbus to 8-bit async SRAM responder.
// The SERV_SRAM8_WAIT_STATE_EN build option is consumed by serv_sram8_responder.
package serv_sram8_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_t;

    // ST_HOLD is only ever entered when the wait-state build option is defined.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_ACK,
        ST_DONE
    } state_t;

    localparam logic STROBE_N_RST = 1'b1;
    localparam logic DAT_OE_RST   = 1'b0;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_t lane);
        logic [7:0] b;
        b = word[7:0];
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/serv_sram8_lane_next.sv
// Lane scheduler: finds the lowest set lane above (or at, when i_incl is set)
// the current lane, so unselected lanes are skipped in zero cycles.
module serv_sram8_lane_next
    import serv_sram8_pkg::*;
(
    input  logic [3:0] i_mask,
    input  lane_t      i_lane,
    input  logic       i_incl,
    output lane_t      o_lane,
    output logic       o_none
);

    always_comb begin
        o_lane = '0;
        o_none = 1'b1;
        // Walk downwards so the lowest qualifying lane is the last one written.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i] && ((i > int'(i_lane)) || (i_incl && (i == int'(i_lane))))) begin
                o_lane = lane_t'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/serv_sram8_responder.sv
// SERV dbus responder: splits each 32-bit access into byte cycles on an 8-bit SRAM.
// Define SERV_SRAM8_WAIT_STATE_EN to stretch every byte strobe by one HOLD cycle.
module serv_sram8_responder
    import serv_sram8_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic [ADDR_W-1:0] o_sram_adr,
    output logic [7:0]        o_sram_dat,
    output logic              o_sram_dat_oe,
    input  logic [7:0]        i_sram_dat,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:2] base_q, base_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        mask_q, mask_d;
    logic              we_q, we_d;
    lane_t             lane_q, lane_d;
    logic              cap_q, cap_d;
    lane_t             cap_lane_q, cap_lane_d;

    logic [31:0]       rdt_q, rdt_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] sram_adr_q, sram_adr_d;
    logic [7:0]        sram_dat_q, sram_dat_d;
    logic              dat_oe_q, dat_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;

    logic              in_idle;
    logic [3:0]        sel_mask;
    logic [3:0]        nx_mask;
    lane_t             nx_cur;
    lane_t             nx_lane;
    logic              nx_none;
    logic              unused_adr_bits;

    assign unused_adr_bits = ^i_wb_adr[1:0];

    // In IDLE the scheduler looks at the incoming request, otherwise at the latched one.
    assign in_idle  = (state_q == ST_IDLE);
    assign sel_mask = i_wb_we ? i_wb_sel : 4'hF;
    assign nx_mask  = in_idle ? sel_mask : mask_q;
    assign nx_cur   = in_idle ? lane_t'(0) : lane_q;

    serv_sram8_lane_next u_lane_next (
        .i_mask (nx_mask),
        .i_lane (nx_cur),
        .i_incl (in_idle),
        .o_lane (nx_lane),
        .o_none (nx_none)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        dat_d   = dat_q;
        mask_d  = mask_q;
        we_d    = we_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    base_d = i_wb_adr[ADDR_W-1:2];
                    dat_d  = i_wb_dat;
                    mask_d = sel_mask;
                    we_d   = i_wb_we;
                    lane_d = nx_lane;
                    state_d = nx_none ? ST_ACK : ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
`ifdef SERV_SRAM8_WAIT_STATE_EN
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD: begin
                lane_d  = nx_none ? lane_q : nx_lane;
                state_d = nx_none ? ST_ACK : ST_SETUP;
            end
`else
            ST_STROBE: begin
                lane_d  = nx_none ? lane_q : nx_lane;
                state_d = nx_none ? ST_ACK : ST_SETUP;
            end
`endif
            ST_ACK:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the registered state, so each pin phase trails the
    // state by one cycle and the read byte is sampled at the end of that phase.
    always_comb begin
        ack_d      = (state_q == ST_ACK);
        sram_adr_d = sram_adr_q;
        sram_dat_d = sram_dat_q;
        dat_oe_d   = DAT_OE_RST;
        ce_n_d     = STROBE_N_RST;
        oe_n_d     = STROBE_N_RST;
        we_n_d     = STROBE_N_RST;
        if (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) begin
            sram_adr_d = {base_q, lane_q};
            ce_n_d     = 1'b0;
            if (we_q) begin
                sram_dat_d = lane_byte(dat_q, lane_q);
                dat_oe_d   = 1'b1;
                we_n_d     = (state_q == ST_SETUP);
            end else begin
                oe_n_d = 1'b0;
            end
        end
`ifdef SERV_SRAM8_WAIT_STATE_EN
        cap_d = (state_q == ST_HOLD) && !we_q;
`else
        cap_d = (state_q == ST_STROBE) && !we_q;
`endif
        cap_lane_d = lane_q;
        rdt_d = rdt_q;
        for (int i = 0; i < LANES; i++) begin
            if (cap_q && (cap_lane_q == lane_t'(i))) begin
                rdt_d[8*i +: 8] = i_sram_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            dat_q      <= '0;
            mask_q     <= '0;
            we_q       <= 1'b0;
            lane_q     <= '0;
            cap_q      <= 1'b0;
            cap_lane_q <= '0;
            rdt_q      <= '0;
            ack_q      <= 1'b0;
            sram_adr_q <= '0;
            sram_dat_q <= '0;
            dat_oe_q   <= DAT_OE_RST;
            ce_n_q     <= STROBE_N_RST;
            oe_n_q     <= STROBE_N_RST;
            we_n_q     <= STROBE_N_RST;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            dat_q      <= dat_d;
            mask_q     <= mask_d;
            we_q       <= we_d;
            lane_q     <= lane_d;
            cap_q      <= cap_d;
            cap_lane_q <= cap_lane_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            sram_adr_q <= sram_adr_d;
            sram_dat_q <= sram_dat_d;
            dat_oe_q   <= dat_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign o_wb_rdt      = rdt_q;
    assign o_wb_ack      = ack_q;
    assign o_sram_adr    = sram_adr_q;
    assign o_sram_dat    = sram_dat_q;
    assign o_sram_dat_oe = dat_oe_q;
    assign o_sram_ce_n   = ce_n_q;
    assign o_sram_oe_n   = oe_n_q;
    assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_serv_sram8_responder.sv
// Bench for serv_sram8_responder: byte-wide SRAM model, vector table, scoreboard
// of expected read words, plus back-to-back and reset-abort sequences.
module tb_serv_sram8_responder;

`ifdef SERV_SRAM8_WAIT_STATE_EN
    localparam int PER = 3;
`else
    localparam int PER = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [15:0] o_sram_adr;
    logic [7:0]  o_sram_dat;
    logic        o_sram_dat_oe;
    logic [7:0]  i_sram_dat;
    logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n;

    logic [7:0]  sram_mem [0:65535];
    logic [7:0]  ref_mem  [0:65535];
    logic [31:0] exp_q[$];
    logic [31:0] last_rdt = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int          ack_cyc, ack_cnt, acc_cnt, we_pulses, we_low, oe_low, viol;
    logic [3:0]  acc_mask;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          exp_ack;
        int          exp_acc;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    serv_sram8_responder dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_wb_adr      (wb_adr),
        .i_wb_dat      (wb_dat),
        .i_wb_sel      (wb_sel),
        .i_wb_we       (wb_we),
        .i_wb_cyc      (wb_cyc),
        .o_wb_rdt      (o_wb_rdt),
        .o_wb_ack      (o_wb_ack),
        .o_sram_adr    (o_sram_adr),
        .o_sram_dat    (o_sram_dat),
        .o_sram_dat_oe (o_sram_dat_oe),
        .i_sram_dat    (i_sram_dat),
        .o_sram_ce_n   (o_sram_ce_n),
        .o_sram_oe_n   (o_sram_oe_n),
        .o_sram_we_n   (o_sram_we_n)
    );

    function automatic logic [7:0] init_byte(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'h5A;
        if (a == 'h124) b = 8'h11;
        if (a == 'h125) b = 8'h22;
        if (a == 'h126) b = 8'h33;
        if (a == 'h127) b = 8'h44;
        return b;
    endfunction

    function automatic int popc(input logic [3:0] s);
        int c = 0;
        for (int i = 0; i < 4; i++) if (s[i]) c++;
        return c;
    endfunction

    // Async SRAM model: reads while ce/oe low, writes while ce/we low.
    assign i_sram_dat = (!o_sram_ce_n && !o_sram_oe_n) ? sram_mem[o_sram_adr] : 8'hEE;

    initial begin
        for (int a = 0; a < 65536; a++) sram_mem[a] = init_byte(a);
        forever begin
            @(negedge clk);
            if (!o_sram_ce_n && !o_sram_we_n && o_sram_dat_oe) sram_mem[o_sram_adr] = o_sram_dat;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Model the access, then drive it and watch the pins until three cycles after ack.
    task automatic run_txn(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        logic [15:0] base;
        logic        p_ce_n, p_we_n;
        logic [15:0] p_adr;
        logic [7:0]  p_dat;
        base = {adr[15:2], 2'b00};
        if (we) begin
            for (int l = 0; l < 4; l++) if (sel[l]) ref_mem[base + l] = dat[8*l +: 8];
        end else begin
            last_rdt = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        end
        exp_q.push_back(last_rdt);
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
        ack_cyc = -1; ack_cnt = 0; acc_cnt = 0; acc_mask = '0;
        we_pulses = 0; we_low = 0; oe_low = 0; viol = 0;
        p_ce_n = 1'b1; p_we_n = 1'b1; p_adr = '0; p_dat = '0;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (!o_sram_ce_n && (p_ce_n || o_sram_adr != p_adr)) begin
                acc_cnt++;
                if (o_sram_adr[15:2] == base[15:2]) acc_mask[o_sram_adr[1:0]] = 1'b1;
                else viol++;
            end
            if (!o_sram_oe_n) oe_low++;
            if (!o_sram_we_n) begin
                we_low++;
                if (!o_sram_dat_oe || o_sram_ce_n) viol++;
                if (p_we_n) begin
                    we_pulses++;
                    if (p_ce_n || p_adr != o_sram_adr || p_dat != o_sram_dat) viol++;
                end
            end
            if (o_wb_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    wb_cyc = 1'b0;
                    check("rdt", o_wb_rdt, exp_q.pop_front());
                end
            end
            p_ce_n = o_sram_ce_n; p_we_n = o_sram_we_n; p_adr = o_sram_adr; p_dat = o_sram_dat;
            if (ack_cyc >= 0 && k >= ack_cyc + 3) break;
        end
        if (ack_cyc < 0) begin
            check("ack_timeout", 32'd0, 32'd1);
            wb_cyc = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        int          n, a2, setup2, ack1, ack2, diffs;
        logic [7:0]  old0, old2, old3;
        logic [15:0] radr;
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(a);
        radr = 16'($urandom_range(16'h1000, 16'hFFFF));

        vecs[0] = '{1'b0, 16'h0126, 32'h0,                  4'b0000, 0, 0};
        vecs[1] = '{1'b1, 16'h0200, 32'hAABBCCDD,           4'b0110, 0, 0};
        vecs[2] = '{1'b1, 16'h0300, 32'h01020304,           4'b0000, 0, 0};
        vecs[3] = '{1'b0, 16'h0203, 32'h0,                  4'b0000, 0, 0};
        vecs[4] = '{1'b1, 16'h0104, 32'h12345678,           4'b1001, 0, 0};
        vecs[5] = '{1'b1, 16'h0109, $urandom(),             4'b1111, 0, 0};
        vecs[6] = '{1'b0, 16'h0105, 32'h0,                  4'b0000, 0, 0};
        vecs[7] = '{1'b0, 16'h010A, 32'h0,                  4'b1111, 0, 0};
        vecs[8] = '{1'b1, radr,     $urandom(), 4'($urandom_range(1, 15)), 0, 0};
        vecs[9] = '{1'b0, radr,     32'h0,                  4'b0000, 0, 0};
        for (int i = 0; i < 10; i++) begin
            n = vecs[i].we ? popc(vecs[i].sel) : 4;
            vecs[i].exp_acc = n;
            vecs[i].exp_ack = 1 + PER * n;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_rdt", o_wb_rdt, 32'd0);
        check("rst_strobes", {28'd0, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_dat_oe}, 32'b1110);
        check("rst_adr_dat", {8'd0, o_sram_adr, o_sram_dat}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
            check($sformatf("v%0d_ack_cycle", i), 32'(ack_cyc), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_ack_width", i), 32'(ack_cnt), 32'd1);
            check($sformatf("v%0d_accesses", i), 32'(acc_cnt), 32'(vecs[i].exp_acc));
            check($sformatf("v%0d_lanes", i), {28'd0, acc_mask}, vecs[i].we ? {28'd0, vecs[i].sel} : 32'hF);
            check($sformatf("v%0d_we_pulses", i), 32'(we_pulses), vecs[i].we ? 32'(vecs[i].exp_acc) : 32'd0);
            check($sformatf("v%0d_we_low", i), 32'(we_low), vecs[i].we ? 32'((PER - 1) * vecs[i].exp_acc) : 32'd0);
            check($sformatf("v%0d_oe_low", i), 32'(oe_low), vecs[i].we ? 32'd0 : 32'(PER * vecs[i].exp_acc));
            check($sformatf("v%0d_strobe_timing", i), 32'(viol), 32'd0);
        end
        check("w_0201", {24'd0, sram_mem[16'h0201]}, 32'hCC);
        check("w_0202", {24'd0, sram_mem[16'h0202]}, 32'hBB);
        check("w_0200_kept", {24'd0, sram_mem[16'h0200]}, {24'd0, init_byte('h200)});
        check("w_0203_kept", {24'd0, sram_mem[16'h0203]}, {24'd0, init_byte('h203)});

        // Back-to-back: cyc held through ACK and DONE, second request accepted at edge 3+PER*4
        ack1 = -1; ack2 = -1; setup2 = -1;
        exp_q.push_back({ref_mem[16'h127], ref_mem[16'h126], ref_mem[16'h125], ref_mem[16'h124]});
        exp_q.push_back({ref_mem[16'h203], ref_mem[16'h202], ref_mem[16'h201], ref_mem[16'h200]});
        last_rdt = exp_q[1];
        wb_adr = 16'h0124; wb_we = 1'b0; wb_sel = 4'h0; wb_cyc = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (ack1 >= 0 && k > ack1 && setup2 < 0 && !o_sram_ce_n) setup2 = k;
            if (o_wb_ack) begin
                if (ack1 < 0) begin
                    ack1 = k;
                    wb_adr = 16'h0200;
                    check("b2b_rdt1", o_wb_rdt, exp_q.pop_front());
                end else begin
                    ack2 = k;
                    wb_cyc = 1'b0;
                    check("b2b_rdt2", o_wb_rdt, exp_q.pop_front());
                    break;
                end
            end
        end
        wb_cyc = 1'b0;
        exp_q.delete();
        a2 = 3 + PER * 4;
        check("b2b_ack1", 32'(ack1), 32'(1 + PER * 4));
        check("b2b_setup2", 32'(setup2), 32'(a2 + 1));
        check("b2b_ack2", 32'(ack2), 32'(a2 + 1 + PER * 4));
        repeat (3) @(posedge clk);
        #1;

        // Reset during the lane-2 strobe of a full-word write
        old0 = ref_mem[16'h0400]; old2 = ref_mem[16'h0402]; old3 = ref_mem[16'h0403];
        wb_adr = 16'h0400; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 + 2 * PER; k++) begin
            @(posedge clk); #1;
        end
        check("abort_lane2_strobe", {15'd0, o_sram_we_n, o_sram_adr}, {15'd0, 1'b0, 16'h0402});
        rst_n = 1'b0;
        wb_cyc = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes", {27'd0, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_dat_oe, o_wb_ack}, 32'b11100);
        check("abort_adr_dat", {8'd0, o_sram_adr, o_sram_dat}, 32'd0);
        check("abort_rdt", o_wb_rdt, 32'd0);
        rst_n = 1'b1;
        last_rdt = '0;
        ack_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (o_wb_ack || !o_sram_ce_n) ack_cnt++;
        end
        check("abort_no_ack", 32'(ack_cnt), 32'd0);
        check("abort_lane0", {24'd0, sram_mem[16'h0400]}, 32'h0D);
        check("abort_lane1", {24'd0, sram_mem[16'h0401]}, 32'hF0);
        check("abort_lane3", {24'd0, sram_mem[16'h0403]}, {24'd0, old3});
        check("abort_lane2", {31'd0, (sram_mem[16'h0402] == old2) || (sram_mem[16'h0402] == 8'hFE)}, 32'd1);
        check("abort_old0_changed", {31'd0, old0 != 8'h0D}, 32'd1);
        ref_mem[16'h0400] = 8'h0D;
        ref_mem[16'h0401] = 8'hF0;
        ref_mem[16'h0402] = sram_mem[16'h0402];

        // Responder resumes normally after the abort
        run_txn(1'b0, 16'h0400, 32'h0, 4'h0);
        check("post_rst_ack_cycle", 32'(ack_cyc), 32'(1 + PER * 4));

        diffs = 0;
        for (int a = 0; a < 65536; a++) if (sram_mem[a] !== ref_mem[a]) diffs++;
        check("mem_image", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
